dequ_seg_adder: RTL and testbench

Parametrised, segmented, pipelined adder for the parallel dequantizer pipe. It adds the reconstruction midpoint `mid` to the extracted bit field `ext` in `NSEG` carry-chained pipeline stages. A final stage formats the result as either two's complement or sign-magnitude. It adds a valid/ready handshake with full-pipeline stall, per-transaction mode, signed-overflow reporting and asynchronous reset.

---
 rtl/dequ_pkg.sv | 27 ++
 rtl/dequ_add_seg.sv | 40 ++++
 rtl/dequ_seg_adder.sv | 163 ++++++++++++++++
 tb/tb_dequ_seg_adder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dequ_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dequ_pkg
// Description : Shared types, defaults and helpers for the dequantizer adder.
// Revision    : 1.0
// ============================================================================
package dequ_pkg;

  typedef enum logic {MODE_TC = 1'b0, MODE_SM = 1'b1} dequ_mode_e;

  localparam int DEQU_WWIDTH = 32;
  localparam int DEQU_NSEG   = 2;

  // Per-beat side information that rides alongside the segmented sum.
  typedef struct packed {
    logic       vld;
    dequ_mode_e mode;
    logic       a_msb;
    logic       b_msb;
  } dequ_side_t;

  function automatic logic dequ_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dequ_add_seg.sv
`default_nettype none
// ============================================================================
// Module      : dequ_add_seg
// Description : One registered SEGW-bit add stage with carry-in/carry-out.
// Revision    : 1.0
// ============================================================================
module dequ_add_seg #(
  parameter int SEGW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic [SEGW-1:0] i_a,
  input  logic [SEGW-1:0] i_b,
  input  logic            i_ci,
  output logic [SEGW-1:0] o_sum,
  output logic            o_co
);

  logic [SEGW:0]   w_add;
  logic [SEGW-1:0] r_sum;
  logic            r_co;

  assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{SEGW{1'b0}}, i_ci};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_co  <= 1'b0;
    end else if (i_en) begin
      r_sum <= w_add[SEGW-1:0];
      r_co  <= w_add[SEGW];
    end
  end

  assign o_sum = r_sum;
  assign o_co  = r_co;

endmodule
`default_nettype wire

// File: rtl/dequ_seg_adder.sv
`default_nettype none
// ============================================================================
// Module      : dequ_seg_adder
// Description : Segmented, pipelined mid+ext adder with TC/SM output format.
// Revision    : 1.0
// ============================================================================
module dequ_seg_adder
  import dequ_pkg::*;
#(
  parameter int WWIDTH = DEQU_WWIDTH,
  parameter int NSEG   = DEQU_NSEG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WWIDTH-1:0] mid,
  input  logic [WWIDTH-1:0] ext,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WWIDTH-1:0] out_sum,
  output logic              out_sign,
  output logic              out_ovf
);

  localparam int SEGW = WWIDTH / NSEG;

  if ((WWIDTH % NSEG) != 0 || NSEG < 1 || NSEG > 8) begin : g_bad_params
    $error("dequ_seg_adder: WWIDTH must be a multiple of NSEG and NSEG in 1..8");
  end

  logic                       w_adv;
  logic [NSEG-1:0][SEGW-1:0]  w_sum;
  logic [NSEG-1:0]            w_co;
  logic [NSEG-1:0][SEGW-1:0]  w_seg_al;
  logic [WWIDTH-1:0]          w_raw;
  logic [WWIDTH-1:0]          w_mag;
  logic                       w_unused_co;
  dequ_side_t                 r_side [NSEG];
  dequ_side_t                 w_side_fmt;

  logic                       r_out_valid;
  logic [WWIDTH-1:0]          r_out_sum;
  logic                       r_out_sign;
  logic                       r_out_ovf;

  // Global stall: every register in the pipe advances or holds together.
  assign w_adv       = !r_out_valid || out_ready;
  assign in_ready    = w_adv;
  assign w_unused_co = w_co[NSEG-1];

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [SEGW-1:0] w_a;
    logic [SEGW-1:0] w_b;
    logic            w_ci;

    if (k == 0) begin : g_direct
      assign w_a  = mid[SEGW-1:0];
      assign w_b  = ext[SEGW-1:0];
      assign w_ci = 1'b0;
    end else begin : g_skew
      // Segment k waits k cycles so it meets the carry rippling up from below.
      logic [SEGW-1:0] r_a [k];
      logic [SEGW-1:0] r_b [k];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < k; j++) begin
            r_a[j] <= '0;
            r_b[j] <= '0;
          end
        end else if (w_adv) begin
          r_a[0] <= mid[k*SEGW +: SEGW];
          r_b[0] <= ext[k*SEGW +: SEGW];
          for (int j = 1; j < k; j++) begin
            r_a[j] <= r_a[j-1];
            r_b[j] <= r_b[j-1];
          end
        end
      end

      assign w_a  = r_a[k-1];
      assign w_b  = r_b[k-1];
      assign w_ci = w_co[k-1];
    end

    dequ_add_seg #(
      .SEGW (SEGW)
    ) u_add (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_adv),
      .i_a   (w_a),
      .i_b   (w_b),
      .i_ci  (w_ci),
      .o_sum (w_sum[k]),
      .o_co  (w_co[k])
    );

    if (k == NSEG - 1) begin : g_last
      assign w_seg_al[k] = w_sum[k];
    end else begin : g_align
      // Lower results wait until the top segment has finished.
      localparam int c_len = NSEG - 1 - k;
      logic [SEGW-1:0] r_al [c_len];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < c_len; j++) begin
            r_al[j] <= '0;
          end
        end else if (w_adv) begin
          r_al[0] <= w_sum[k];
          for (int j = 1; j < c_len; j++) begin
            r_al[j] <= r_al[j-1];
          end
        end
      end

      assign w_seg_al[k] = r_al[c_len-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        r_side[k] <= '0;
      end
    end else if (w_adv) begin
      r_side[0] <= '{vld: in_valid, mode: dequ_mode_e'(mode),
                     a_msb: mid[WWIDTH-1], b_msb: ext[WWIDTH-1]};
      for (int k = 1; k < NSEG; k++) begin
        r_side[k] <= r_side[k-1];
      end
    end
  end

  assign w_side_fmt = r_side[NSEG-1];
  assign w_raw      = w_seg_al;
  assign w_mag      = w_raw[WWIDTH-1] ? (~w_raw + WWIDTH'(1)) : w_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_sign  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_side_fmt.vld;
      r_out_sum   <= (w_side_fmt.mode == MODE_SM) ? w_mag : w_raw;
      r_out_sign  <= w_raw[WWIDTH-1];
      r_out_ovf   <= dequ_ovf(w_side_fmt.a_msb, w_side_fmt.b_msb, w_raw[WWIDTH-1]);
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_sign  = r_out_sign;
  assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dequ_seg_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dequ_seg_adder
// Description : Random + directed bench for dequ_seg_adder at NSEG = 2, 1, 4, 8.
// Revision    : 1.0
// ============================================================================
module tb_dequ_seg_adder;

  localparam int NI = 4;

  typedef struct {
    logic [31:0] sum;
    logic        sign;
    logic        ovf;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] mid = '0;
  logic [31:0] ext = '0;
  logic        mode = 1'b0;

  logic        ir   [NI];
  logic        ov   [NI];
  logic        ordy [NI];
  logic [31:0] os   [NI];
  logic        osg  [NI];
  logic        oof  [NI];
  int          nseg_of [NI];

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic lat_chk = 1'b1;
  exp_t sbq [NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    localparam int c_ns = (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 4 : 8;
    initial nseg_of[i] = c_ns;
    dequ_seg_adder #(
      .WWIDTH (32),
      .NSEG   (c_ns)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[i]),
      .mid       (mid),
      .ext       (ext),
      .mode      (mode),
      .out_valid (ov[i]),
      .out_ready (ordy[i]),
      .out_sum   (os[i]),
      .out_sign  (osg[i]),
      .out_ovf   (oof[i])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: exact integer sum, then wrap / overflow / magnitude by definition.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic m, input int t);
    exp_t   e;
    longint s;
    logic [31:0] raw;
    s     = longint'($signed(a)) + longint'($signed(b));
    raw   = 32'(s);
    e.sign = raw[31];
    e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.sum  = (m && raw[31]) ? 32'(64'h1_0000_0000 - {32'h0, raw}) : raw;
    e.t    = t;
    return e;
  endfunction

  exp_t        m_e;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_sum;
  logic        prev_sign, prev_ovf;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        if (ov[i] && ordy[i]) begin
          if (sbq[i].size() == 0) begin
            check($sformatf("spurious_out[%0d]", i), 64'd1, 64'd0);
          end else begin
            m_e = sbq[i].pop_front();
            check($sformatf("sum[%0d]", i), {32'h0, os[i]}, {32'h0, m_e.sum});
            check($sformatf("sign[%0d]", i), {63'h0, osg[i]}, {63'h0, m_e.sign});
            check($sformatf("ovf[%0d]", i), {63'h0, oof[i]}, {63'h0, m_e.ovf});
            if (i != 0 || lat_chk)
              check($sformatf("latency[%0d]", i), 64'(cyc - m_e.t), 64'(nseg_of[i] + 1));
          end
        end
        if (in_valid && ir[i]) sbq[i].push_back(model(mid, ext, mode, cyc));
      end
      if (prev_stall) begin
        check("stall_hold_sum", {32'h0, os[0]}, {32'h0, prev_sum});
        check("stall_hold_flags", {62'h0, osg[0], oof[0]}, {62'h0, prev_sign, prev_ovf});
        check("stall_hold_valid", {63'h0, ov[0]}, 64'd1);
      end
      prev_stall = ov[0] && !ordy[0];
      prev_sum   = os[0];
      prev_sign  = osg[0];
      prev_ovf   = oof[0];
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic m);
    int n;
    in_valid = 1'b1;
    mid = a;
    ext = b;
    mode = m;
    n = 0;
    forever begin
      @(negedge clk);
      if (ir[0]) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single directed beat: checks result constants and latency on the main DUT.
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic [31:0] xs, input logic xg, input logic xo);
    int k;
    send(a, b, m);
    in_valid = 1'b0;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (ov[0] || k > 20) break;
    end
    check({tag, "_lat"}, 64'(k), 64'd3);
    check({tag, "_sum"}, {32'h0, os[0]}, {32'h0, xs});
    check({tag, "_sign"}, {63'h0, osg[0]}, {63'h0, xg});
    check({tag, "_ovf"}, {63'h0, oof[0]}, {63'h0, xo});
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NI; i++) ordy[i] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", {63'h0, ov[0]}, 64'd0);
    check("rst_out_sum", {32'h0, os[0]}, 64'd0);
    check("rst_flags", {62'h0, osg[0], oof[0]}, 64'd0);
    check("rst_in_ready", {63'h0, ir[0]}, 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;

    directed("carry", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0);
    directed("neg_sm", 32'h00000005, 32'hFFFFFFF0, 1'b1, 32'h0000000B, 1'b1, 1'b0);
    directed("neg_tc", 32'h00000005, 32'hFFFFFFF0, 1'b0, 32'hFFFFFFF5, 1'b1, 1'b0);
    directed("ovf_pos", 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b1, 1'b1);
    directed("ovf_neg", 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);

    // Backpressure: out_ready low for stream cycles 4..9.
    lat_chk = 1'b0;
    fork
      begin
        for (int b = 0; b < 10; b++) send($urandom, $urandom, 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        repeat (4) begin @(posedge clk); #1; end
        ordy[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        check("bp_in_ready_low", {63'h0, ir[0]}, 64'd0);
        check("bp_in_flight", 64'(sbq[0].size()), 64'd3);
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
      end
    join
    idle(12);
    check("bp_drained", 64'(sbq[0].size()), 64'd0);
    lat_chk = 1'b1;

    // Reset mid-stream with beats in flight.
    for (int b = 0; b < 3; b++) send($urandom, $urandom, 1'($urandom));
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) sbq[i].delete();
    #1;
    check("arst_out_valid", {63'h0, ov[0]}, 64'd0);
    check("arst_out_sum", {32'h0, os[0]}, 64'd0);
    check("arst_flags", {62'h0, osg[0], oof[0]}, 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    directed("post_rst", 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0);

    // Back-to-back random stream, all instances checked by the monitor.
    for (int b = 0; b < 1000; b++) begin
      case ($urandom_range(0, 3))
        0:       send($urandom, $urandom, 1'($urandom));
        1:       send(32'h7FFF0000 | 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 131071)), 1'($urandom));
        2:       send(32'h80000000 | 32'($urandom_range(0, 15)), 32'hFFFFFFF0 | 32'($urandom_range(0, 15)), 1'($urandom));
        default: send(32'($urandom_range(0, 65535)), 32'hFFFF0000 | 32'($urandom_range(0, 65535)), 1'($urandom));
      endcase
    end
    idle(20);
    for (int i = 0; i < NI; i++) check($sformatf("drained[%0d]", i), 64'(sbq[i].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
